// File: rtl/serial_load_ctrl_if.sv
// Bundle of the word-load handshake and the serial chain drive signals
// for serial_load_ctrl. The master side supplies words and abort; the
// slave side (the controller) drives the chain and the status strobes.
interface serial_load_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             abort;
  logic             ser_d;
  logic             shift_en;
  logic             latch;
  logic             busy;
  logic             done;

  modport master (
    output in_data, in_valid, abort,
    input  in_ready, ser_d, shift_en, latch, busy, done
  );

  modport slave (
    input  in_data, in_valid, abort,
    output in_ready, ser_d, shift_en, latch, busy, done
  );
endinterface

// File: rtl/serial_load_ctrl.sv
// Serial load controller: accepts a parallel word, shifts it bit by bit
// into an external flip-flop chain through ser_d/shift_en, then strobes
// latch/done for one cycle so the chain is copied to its holding register.
// An abort during shifting drops the word without the latch strobe.
module serial_load_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic           clk,
  input logic           reset,
  serial_load_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] shadow_r;
  logic             ser_d_r;
  logic             shift_en_r;
  logic             latch_r;
  logic             done_r;
  logic             busy_r;

  // Bit of the shadow word presented on ser_d for a given shift count,
  // honouring the configured shift order.
  function automatic logic pick_bit(input logic [WIDTH-1:0] word,
                                    input logic [CW-1:0]    idx);
    logic [CW-1:0] pos;
    if (MSB_FIRST) begin
      pos = CW'(WIDTH - 1) - idx;
    end else begin
      pos = idx;
    end
    return word[pos];
  endfunction

  // Ready is a pure decode of IDLE, masked while reset is held so no word
  // can be offered during a reset cycle.
  assign bus.in_ready = (state_r == IDLE) && !reset;
  assign bus.ser_d    = ser_d_r;
  assign bus.shift_en = shift_en_r;
  assign bus.latch    = latch_r;
  assign bus.done     = done_r;
  assign bus.busy     = busy_r;

  // Controller FSM with registered chain drive and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      count_r    <= {CW{1'b0}};
      shadow_r   <= {WIDTH{1'b0}};
      ser_d_r    <= 1'b0;
      shift_en_r <= 1'b0;
      latch_r    <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          latch_r <= 1'b0;
          done_r  <= 1'b0;
          if (bus.in_valid) begin
            // Word captured here; later in_data changes cannot reach the chain.
            shadow_r   <= bus.in_data;
            count_r    <= {CW{1'b0}};
            state_r    <= SHIFT;
            shift_en_r <= 1'b1;
            ser_d_r    <= pick_bit(bus.in_data, {CW{1'b0}});
            busy_r     <= 1'b1;
          end else begin
            shift_en_r <= 1'b0;
            ser_d_r    <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            state_r    <= IDLE;
            shift_en_r <= 1'b0;
            ser_d_r    <= 1'b0;
            busy_r     <= 1'b0;
            latch_r    <= 1'b0;
            done_r     <= 1'b0;
          end else if (count_r == CW'(WIDTH - 1)) begin
            // Last bit is being clocked in now; strobe the holding register next.
            state_r    <= LATCH;
            count_r    <= count_r + CW'(1);
            shift_en_r <= 1'b0;
            ser_d_r    <= 1'b0;
            latch_r    <= 1'b1;
            done_r     <= 1'b1;
            busy_r     <= 1'b1;
          end else begin
            count_r    <= count_r + CW'(1);
            ser_d_r    <= pick_bit(shadow_r, count_r + CW'(1));
            shift_en_r <= 1'b1;
            latch_r    <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        LATCH: begin
          state_r    <= IDLE;
          shift_en_r <= 1'b0;
          ser_d_r    <= 1'b0;
          latch_r    <= 1'b0;
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          count_r    <= {CW{1'b0}};
          shift_en_r <= 1'b0;
          ser_d_r    <= 1'b0;
          latch_r    <= 1'b0;
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Bench for serial_load_ctrl: two instances (MSB-first and LSB-first)
// share one stimulus stream. A cycle-count reference model predicts every
// output each cycle; accepted words go into a scoreboard queue that a
// separate monitor pops whenever a latch strobe appears and compares
// against the serial bits it collected from both chains.
module tb_serial_load_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         tb_reset;
  logic         tb_valid;
  logic [W-1:0] tb_data;
  logic         tb_abort;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int n_words   = 0;
  bit chk_en    = 1'b0;

  // Reference model: rem counts the cycles the current word still occupies
  // the controller (W+1..2 shifting, 1 latching, 0 idle).
  int           rem = 0;
  logic [W-1:0] cur = '0;
  logic [W-1:0] exp_q[$];

  serial_load_ctrl_if #(.WIDTH(W)) if_m ();
  serial_load_ctrl_if #(.WIDTH(W)) if_l ();

  assign if_m.in_valid = tb_valid;
  assign if_m.in_data  = tb_data;
  assign if_m.abort    = tb_abort;
  assign if_l.in_valid = tb_valid;
  assign if_l.in_data  = tb_data;
  assign if_l.abort    = tb_abort;

  serial_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .reset (tb_reset),
    .bus   (if_m)
  );

  serial_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .reset (tb_reset),
    .bus   (if_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] reverse(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs held for it.
  task automatic model_step();
    if (tb_reset) begin
      if (rem >= 2) void'(exp_q.pop_back());
      rem = 0;
    end else if (rem == 0) begin
      if (tb_valid) begin
        cur = tb_data;
        exp_q.push_back(tb_data);
        rem = W + 1;
      end
    end else if (rem >= 2 && tb_abort) begin
      void'(exp_q.pop_back());
      rem = 0;
    end else begin
      rem = rem - 1;
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic a, input logic r);
    tb_valid = v;
    tb_data  = d;
    tb_abort = a;
    tb_reset = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic rdy, input logic se,
                               input logic sd, input logic la, input logic dn,
                               input logic bz, input logic exp_sd);
    logic exp_se;
    logic exp_la;
    exp_se = (rem >= 2);
    exp_la = (rem == 1);
    check({tag, "_in_ready"}, {31'd0, rdy}, {31'd0, (rem == 0) && !tb_reset});
    check({tag, "_shift_en"}, {31'd0, se}, {31'd0, exp_se});
    check({tag, "_ser_d"},    {31'd0, sd}, {31'd0, exp_sd});
    check({tag, "_latch"},    {31'd0, la}, {31'd0, exp_la});
    check({tag, "_done"},     {31'd0, dn}, {31'd0, exp_la});
    check({tag, "_busy"},     {31'd0, bz}, {31'd0, rem != 0});
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int idx;
      logic sd_m;
      logic sd_l;
      idx  = W + 1 - rem;
      sd_m = (rem >= 2) ? cur[W-1-idx] : 1'b0;
      sd_l = (rem >= 2) ? cur[idx] : 1'b0;
      check_outputs("msb", if_m.in_ready, if_m.shift_en, if_m.ser_d,
                    if_m.latch, if_m.done, if_m.busy, sd_m);
      check_outputs("lsb", if_l.in_ready, if_l.shift_en, if_l.ser_d,
                    if_l.latch, if_l.done, if_l.busy, sd_l);
    end
  end

  // Scoreboard monitor: collect each shift burst, compare on latch.
  logic [W-1:0] bits_m = '0;
  logic [W-1:0] bits_l = '0;
  int           cnt_m  = 0;
  int           cnt_l  = 0;
  logic         prev_la_m = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic [W-1:0] word;
      if (if_m.shift_en) begin
        bits_m = {bits_m[W-2:0], if_m.ser_d};
        cnt_m++;
      end
      if (if_l.shift_en) begin
        bits_l = {bits_l[W-2:0], if_l.ser_d};
        cnt_l++;
      end
      if (if_m.latch && prev_la_m) begin
        check("latch_twice", 32'd1, 32'd0);
      end
      prev_la_m = if_m.latch;
      if (if_m.latch || if_l.latch) begin
        if (exp_q.size() == 0) begin
          check("latch_without_word", 32'd1, 32'd0);
        end else begin
          word = exp_q.pop_front();
          n_words++;
          check("stream_msb", {24'd0, bits_m}, {24'd0, word});
          check("stream_lsb", {24'd0, bits_l}, {24'd0, reverse(word)});
          check("burst_len_msb", cnt_m, W);
          check("burst_len_lsb", cnt_l, W);
        end
        cnt_m = 0;
        cnt_l = 0;
      end else begin
        if (!if_m.shift_en) cnt_m = 0;
        if (!if_l.shift_en) cnt_l = 0;
      end
    end
  end

  initial begin
    tb_valid = 1'b0;
    tb_data  = '0;
    tb_abort = 1'b0;
    tb_reset = 1'b1;

    // Reset, then verify reset outputs from the second reset cycle on.
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    chk_en = 1'b1;
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Single word 0xC4, both shift orders.
    step(1'b1, 8'hC4, 1'b0, 1'b0);
    repeat (W + 2) step(1'b0, 8'h00, 1'b0, 1'b0);

    // in_valid held high: 0x01 then 0x80, in_data toggling mid-shift.
    step(1'b1, 8'h01, 1'b0, 1'b0);
    repeat (W + 1) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'h80, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (W + 2) step(1'b0, 8'h00, 1'b0, 1'b0);

    // 0xFF aborted on the 4th shift cycle.
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset during shift bit 5, then 0xA5 runs to completion.
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    repeat (W + 2) step(1'b0, 8'h00, 1'b0, 1'b0);

    check("directed_words", n_words, 4);

    // Random stress on in_valid/abort/reset.
    for (int c = 0; c < 10000; c++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));
    end
    repeat (W + 3) step(1'b0, 8'h00, 1'b0, 1'b0);

    check("queue_drained", exp_q.size(), 0);
    check("words_completed", {31'd0, n_words > 100}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_load_ctrl.md
SERIAL_LOAD_CTRL -- requirements
Module: serial_load_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets the number of flip-flops in the driven chain and the word width; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 Port in_data, input, WIDTH bits: parallel word to load into the chain.
REQ-006 Port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 Port in_ready, output, 1 bit: controller will accept a word this cycle.
REQ-008 Port abort, input, 1 bit: cancels an in-progress shift.
REQ-009 Port ser_d, output, 1 bit: serial data to the D input of the first chain flip-flop.
REQ-010 Port shift_en, output, 1 bit: chain clock enable; chain captures ser_d on edges where shift_en=1.
REQ-011 Port latch, output, 1 bit: one-cycle strobe copying the chain into the output holding register.
REQ-012 Port busy, output, 1 bit: high in SHIFT and LATCH states.
REQ-013 Port done, output, 1 bit: one-cycle pulse, coincident with latch, on successful completion.

Function
REQ-014 The block SHALL implement exactly three states, IDLE, SHIFT and LATCH, plus a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-015 in_ready SHALL equal (state==IDLE) AND NOT reset; no other state SHALL assert it.
REQ-016 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_data is captured into an internal shadow register, counter cleared, state -> SHIFT.
REQ-017 in_valid and in_data SHALL be ignored whenever in_ready=0; later changes to in_data SHALL not affect the word in flight.
REQ-018 In SHIFT, shift_en SHALL be 1 and ser_d SHALL present shadow bit (WIDTH-1-count) when MSB_FIRST=1, bit (count) when MSB_FIRST=0.
REQ-019 For an acceptance edge at cycle k, shift_en SHALL be high for exactly cycles k+1..k+WIDTH, contiguous, and low at all other times.
REQ-020 After the WIDTH-th SHIFT cycle, state SHALL -> LATCH; latch=1 and done=1 for cycle k+WIDTH+1 only.
REQ-021 LATCH SHALL -> IDLE unconditionally; in_ready returns to 1 at cycle k+WIDTH+2; maximum throughput one word per WIDTH+2 cycles.
REQ-022 abort=1 on any SHIFT-state edge SHALL -> IDLE next cycle; no latch, no done; chain contents are then undefined to consumers.
REQ-023 abort SHALL be ignored in IDLE and LATCH; abort and in_valid together in IDLE SHALL accept the word.
REQ-024 ser_d SHALL be 0 whenever shift_en=0.
REQ-025 latch and done SHALL never be high for two consecutive cycles.

Reset
REQ-026 On any rising edge with reset=1: state=IDLE, counter=0, shadow=0; reset SHALL take priority over in_valid and abort.
REQ-027 While reset=1 and on the first cycle after it: shift_en=0, ser_d=0, latch=0, done=0, busy=0; in_ready=0 while reset=1, 1 from the first cycle with reset=0.
REQ-028 Reset asserted mid-SHIFT or in LATCH SHALL abandon the word with no latch/done pulse after the reset edge.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1, accept 0xC4 at cycle k -> shift_en high k+1..k+8, ser_d = 1,1,0,0,0,1,0,0; latch=done=1 at k+9; in_ready=1 at k+10.
REQ-030 WIDTH=8, MSB_FIRST=0, accept 0xC4 -> ser_d = 0,0,1,0,0,0,1,1; single latch pulse at k+9.
REQ-031 in_valid held high continuously with words 0x01, 0x80 -> second acceptance exactly at k+10; no word lost or duplicated; in_data toggled mid-shift has no effect on ser_d.
REQ-032 Accept 0xFF, abort=1 at 4th shift cycle -> shift_en low next cycle, busy=0, no latch/done, in_ready=1.
REQ-033 reset=1 for one cycle during SHIFT bit 5 -> all outputs 0 next cycle, in_ready=1 once reset=0, no latch; following word 0xA5 completes normally.
REQ-034 Random in_valid/abort/reset stress, 10k cycles -> shift_en bursts exactly WIDTH long before every latch; latch/done always one cycle; in_ready never high while busy=1.
